lvds_adc_aligner: RTL and testbench

Parametrised fabric-side successor to the fixed-mapping LTC2195 receiver.
- Takes per-lane ISERDESE2 parallel words in the DCO_2D domain.
- Applies per-lane polarity correction and trains bitslip automatically against the frame lane.
- Assembles N_CHANNELS ADC samples with a valid flag and keeps monitoring frame integrity.
- Sits between the per-lane IBUFDS/IDELAYE2/ISERDESE2 chain and the servo datapath; it drives the shared ISERDES BITSLIP input.

---
 rtl/lvds_adc_pkg.sv | 32 +++
 rtl/lvds_adc_align_fsm.sv | 151 +++++++++++++++
 rtl/lvds_adc_aligner.sv | 96 +++++++++
 tb/tb_lvds_adc_aligner.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_adc_pkg.sv
// Shared types and defaults for the LVDS ADC lane aligner: FSM states,
// LTC2195 lane polarity/frame defaults and the lane-to-sample bit mapping.
package lvds_adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SLIP,
    WAIT,
    LOCKED,
    FAIL
  } align_state_e;

  localparam logic [8:0] LTC2195_INVERT_LANES  = 9'h1D0;
  localparam logic [3:0] LTC2195_FRAME_PATTERN = 4'b0011;

  // Flat raw_data index feeding bit bit_idx of channel ch. Lane pairs are
  // interleaved bit by bit, MSB first.
  function automatic int src_bit_index(input int ch, input int bit_idx,
                                       input int lanes_per_ch, input int ser_width);
    int k;
    int p;
    int r;
    int lane;
    k    = lanes_per_ch * ser_width - 1 - bit_idx;
    p    = k / (2 * ser_width);
    r    = k % (2 * ser_width);
    lane = ch * lanes_per_ch + 2 * p + (r % 2);
    return lane * ser_width + r / 2;
  endfunction

endpackage

// File: rtl/lvds_adc_align_fsm.sv
// Bitslip training / lock supervision FSM driven only by the corrected frame
// word, plus the slip, match, loss and error statistics counters.
module lvds_adc_align_fsm
  import lvds_adc_pkg::*;
#(
  parameter int                   SER_WIDTH     = 4,
  parameter logic [SER_WIDTH-1:0] FRAME_PATTERN = LTC2195_FRAME_PATTERN,
  parameter int                   MATCH_CNT     = 16,
  parameter int                   LOSS_CNT      = 4,
  parameter int                   SLIP_WAIT     = 4,
  parameter int                   MAX_SLIPS     = 2 * SER_WIDTH
) (
  input  logic                               clk_i,
  input  logic                               srst_i,
  input  logic                               serdes_rdy_i,
  input  logic                               train_start_i,
  input  logic [SER_WIDTH-1:0]               frame_word_i,
  output logic                               bitslip_o,
  output logic                               locked_o,
  output logic                               align_fail_o,
  output logic                               valid_next_o,
  output logic [$clog2(MAX_SLIPS+1)-1:0]     slip_count_o,
  output logic [15:0]                        frame_err_cnt_o,
  output logic [7:0]                         relock_cnt_o
);

  localparam int SLIP_W  = $clog2(MAX_SLIPS + 1);
  localparam int MATCH_W = $clog2(MATCH_CNT + 1);
  localparam int LOSS_W  = $clog2(LOSS_CNT + 1);
  localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);

  align_state_e       state_q, state_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [SLIP_W-1:0]  slip_q, slip_d;
  logic [15:0]        err_q, err_d;
  logic [7:0]         relock_q, relock_d;
  logic               frame_ok;

  assign frame_ok = (frame_word_i == FRAME_PATTERN);

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    loss_d   = loss_q;
    wait_d   = wait_q;
    slip_d   = slip_q;
    err_d    = err_q;
    relock_d = relock_q;
    case (state_q)
      IDLE: begin
        state_d = CHECK;
        match_d = '0;
        slip_d  = '0;
      end
      CHECK: begin
        if (frame_ok) begin
          if (match_q == MATCH_W'(MATCH_CNT - 1)) begin
            state_d = LOCKED;
            match_d = '0;
            loss_d  = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end else begin
          match_d = '0;
          state_d = (slip_q == SLIP_W'(MAX_SLIPS)) ? FAIL : SLIP;
        end
      end
      SLIP: begin
        slip_d  = slip_q + 1'b1;
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == WAIT_W'(SLIP_WAIT - 1)) begin
          wait_d  = '0;
          state_d = CHECK;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      LOCKED: begin
        if (frame_ok) begin
          loss_d = '0;
        end else begin
          err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
          if (loss_q == LOSS_W'(LOSS_CNT - 1)) begin
            state_d  = CHECK;
            loss_d   = '0;
            match_d  = '0;
            slip_d   = '0;
            relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
          end else begin
            loss_d = loss_q + 1'b1;
          end
        end
      end
      FAIL:    state_d = FAIL;
      default: state_d = IDLE;
    endcase

    // Link-down beats retrain; both override any decision taken above.
    if (!serdes_rdy_i) begin
      state_d = IDLE;
      match_d = '0;
      loss_d  = '0;
      wait_d  = '0;
      slip_d  = '0;
    end else if (train_start_i) begin
      state_d  = CHECK;
      match_d  = '0;
      loss_d   = '0;
      wait_d   = '0;
      slip_d   = '0;
      err_d    = '0;
      relock_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q  <= IDLE;
      match_q  <= '0;
      loss_q   <= '0;
      wait_q   <= '0;
      slip_q   <= '0;
      err_q    <= '0;
      relock_q <= '0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      loss_q   <= loss_d;
      wait_q   <= wait_d;
      slip_q   <= slip_d;
      err_q    <= err_d;
      relock_q <= relock_d;
    end
  end

  assign bitslip_o       = (state_q == SLIP);
  assign locked_o        = (state_q == LOCKED);
  assign align_fail_o    = (state_q == FAIL);
  // Samples taken in the cycle that loses lock are not flagged valid.
  assign valid_next_o    = (state_q == LOCKED) && (state_d == LOCKED);
  assign slip_count_o    = slip_q;
  assign frame_err_cnt_o = err_q;
  assign relock_cnt_o    = relock_q;

endmodule

// File: rtl/lvds_adc_aligner.sv
// LVDS ADC receiver back end: lane polarity correction, frame extraction,
// lane-pair to sample bit mapping and registered outputs around the align FSM.
module lvds_adc_aligner
  import lvds_adc_pkg::*;
#(
  parameter int                   N_CHANNELS    = 2,
  parameter int                   LANES_PER_CH  = 4,
  parameter int                   SER_WIDTH     = 4,
  parameter int                   ADC_BITS      = LANES_PER_CH * SER_WIDTH,
  parameter int                   N_LANES       = N_CHANNELS * LANES_PER_CH + 1,
  parameter logic [N_LANES-1:0]   INVERT_LANES  = LTC2195_INVERT_LANES,
  parameter logic [SER_WIDTH-1:0] FRAME_PATTERN = LTC2195_FRAME_PATTERN,
  parameter int                   MATCH_CNT     = 16,
  parameter int                   LOSS_CNT      = 4,
  parameter int                   SLIP_WAIT     = 4,
  parameter int                   MAX_SLIPS     = 2 * SER_WIDTH
) (
  input  logic                             DCO_2D,
  input  logic                             rst_in,
  input  logic                             serdes_rdy,
  input  logic                             train_start,
  input  logic [N_LANES*SER_WIDTH-1:0]     raw_data,
  output logic                             bitslip,
  output logic [N_CHANNELS*ADC_BITS-1:0]   adc_data,
  output logic                             adc_valid,
  output logic [SER_WIDTH-1:0]             frame_out,
  output logic                             locked,
  output logic                             align_fail,
  output logic [$clog2(MAX_SLIPS+1)-1:0]   slip_count,
  output logic [15:0]                      frame_err_cnt,
  output logic [7:0]                       relock_cnt
);

  logic [N_LANES*SER_WIDTH-1:0]   inv_mask;
  logic [N_LANES*SER_WIDTH-1:0]   mod_data;
  logic [SER_WIDTH-1:0]           frame_word;
  logic [N_CHANNELS*ADC_BITS-1:0] adc_d, adc_q;
  logic [SER_WIDTH-1:0]           frame_q;
  logic                           valid_d, valid_q;

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    assign inv_mask[gi*SER_WIDTH +: SER_WIDTH] = {SER_WIDTH{INVERT_LANES[gi]}};
  end
  assign mod_data = raw_data ^ inv_mask;

  // Q4 arrives first, so it becomes the LSB of the frame word.
  for (genvar gi = 0; gi < SER_WIDTH; gi++) begin : g_frame
    assign frame_word[gi] = mod_data[(N_LANES-1)*SER_WIDTH + SER_WIDTH-1-gi];
  end

  for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_ch
    for (genvar gj = 0; gj < ADC_BITS; gj++) begin : g_bit
      localparam int SRC = src_bit_index(gi, gj, LANES_PER_CH, SER_WIDTH);
      assign adc_d[gi*ADC_BITS + gj] = mod_data[SRC];
    end
  end

  lvds_adc_align_fsm #(
    .SER_WIDTH    (SER_WIDTH),
    .FRAME_PATTERN(FRAME_PATTERN),
    .MATCH_CNT    (MATCH_CNT),
    .LOSS_CNT     (LOSS_CNT),
    .SLIP_WAIT    (SLIP_WAIT),
    .MAX_SLIPS    (MAX_SLIPS)
  ) u_fsm (
    .clk_i          (DCO_2D),
    .srst_i         (rst_in),
    .serdes_rdy_i   (serdes_rdy),
    .train_start_i  (train_start),
    .frame_word_i   (frame_word),
    .bitslip_o      (bitslip),
    .locked_o       (locked),
    .align_fail_o   (align_fail),
    .valid_next_o   (valid_d),
    .slip_count_o   (slip_count),
    .frame_err_cnt_o(frame_err_cnt),
    .relock_cnt_o   (relock_cnt)
  );

  always_ff @(posedge DCO_2D) begin
    if (rst_in) begin
      adc_q   <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
    end else begin
      adc_q   <= adc_d;
      frame_q <= frame_word;
      valid_q <= valid_d;
    end
  end

  assign adc_data  = adc_q;
  assign frame_out = frame_q;
  assign adc_valid = valid_q;

endmodule

// File: tb/tb_lvds_adc_aligner.sv
// Directed + randomized bench for lvds_adc_aligner with a rotating-frame
// ISERDES model and an arithmetic lane-mapping reference.
module tb_lvds_adc_aligner;

  localparam int             SW   = 4;
  localparam int             NCH  = 2;
  localparam int             LPC  = 4;
  localparam int             ADCB = 16;
  localparam int             NL   = 9;
  localparam logic [NL-1:0]  MASK = 9'h1D0;
  localparam logic [SW-1:0]  FP   = 4'b0011;

  logic                 DCO_2D;
  logic                 rst_in;
  logic                 serdes_rdy;
  logic                 train_start;
  logic [NL*SW-1:0]     raw_data;
  logic                 bitslip;
  logic [NCH*ADCB-1:0]  adc_data;
  logic                 adc_valid;
  logic [SW-1:0]        frame_out;
  logic                 locked;
  logic                 align_fail;
  logic [3:0]           slip_count;
  logic [15:0]          frame_err_cnt;
  logic [7:0]           relock_cnt;

  lvds_adc_aligner dut (
    .DCO_2D       (DCO_2D),
    .rst_in       (rst_in),
    .serdes_rdy   (serdes_rdy),
    .train_start  (train_start),
    .raw_data     (raw_data),
    .bitslip      (bitslip),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .frame_out    (frame_out),
    .locked       (locked),
    .align_fail   (align_fail),
    .slip_count   (slip_count),
    .frame_err_cnt(frame_err_cnt),
    .relock_cnt   (relock_cnt)
  );

  initial DCO_2D = 1'b0;
  always #5 DCO_2D = ~DCO_2D;

  int checks   = 0;
  int failures = 0;

  // ISERDES / source model state
  int            rot;
  logic          frame_zero;
  logic          frame_bad;
  logic [31:0]   data_raw;
  logic [NL*SW-1:0] raw_prev;
  int            cycle;
  int            pulse_cnt;
  int            last_pulse;
  int            min_gap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] rotl(input logic [SW-1:0] v, input int r);
    logic [2*SW-1:0] t;
    t = {v, v} << r;
    return t[2*SW-1:SW];
  endfunction

  function automatic logic [NL*SW-1:0] mask_rep();
    logic [NL*SW-1:0] m;
    for (int ln = 0; ln < NL; ln++)
      for (int s = 0; s < SW; s++) m[ln*SW+s] = MASK[ln];
    return m;
  endfunction

  // Reference: walk lane pairs / serdes slots and place each bit by formula.
  function automatic logic [NCH*ADCB-1:0] exp_adc(input logic [NL*SW-1:0] raw);
    logic [NCH*ADCB-1:0] e;
    e = '0;
    for (int c = 0; c < NCH; c++)
      for (int p = 0; p < LPC/2; p++)
        for (int s = 0; s < SW; s++)
          for (int l = 0; l < 2; l++) begin
            int lane;
            int k;
            lane = c*LPC + 2*p + l;
            k    = p*2*SW + 2*s + l;
            e[c*ADCB + ADCB-1-k] = raw[lane*SW+s] ^ MASK[lane];
          end
    return e;
  endfunction

  function automatic logic [SW-1:0] exp_frame(input logic [NL*SW-1:0] raw);
    logic [SW-1:0] f;
    for (int i = 0; i < SW; i++) f[i] = raw[(NL-1)*SW + SW-1-i] ^ MASK[NL-1];
    return f;
  endfunction

  task automatic drive_raw();
    logic [SW-1:0] fw;
    logic [SW-1:0] lane_bits;
    if (frame_zero) begin
      lane_bits = '0;
    end else begin
      fw = rotl(FP, rot);
      if (frame_bad) fw = ~fw;
      for (int i = 0; i < SW; i++) lane_bits[SW-1-i] = fw[i] ^ MASK[NL-1];
    end
    raw_data = {lane_bits, data_raw};
  endtask

  task automatic set_data_mod(input logic [31:0] m);
    logic [NL*SW-1:0] mr;
    mr = mask_rep();
    data_raw = m ^ mr[31:0];
    drive_raw();
  endtask

  task automatic tick();
    logic bs;
    bs = bitslip;
    raw_prev = raw_data;
    @(posedge DCO_2D);
    #1;
    cycle++;
    if (bs) begin
      if (pulse_cnt > 0 && (cycle - last_pulse) < min_gap) min_gap = cycle - last_pulse;
      last_pulse = cycle;
      pulse_cnt++;
      rot = (rot + SW - 1) % SW;
    end
    drive_raw();
  endtask

  task automatic clear_pulses();
    pulse_cnt = 0;
    min_gap   = 1000;
    last_pulse = 0;
  endtask

  initial begin
    logic [NCH*ADCB-1:0] e;
    int pc;
    rst_in = 1'b1; serdes_rdy = 1'b0; train_start = 1'b0;
    rot = 0; frame_zero = 1'b0; frame_bad = 1'b0; data_raw = '0; cycle = 0;
    clear_pulses();
    drive_raw();
    repeat (3) tick();

    // Reset state
    chk("rst_outputs", {bitslip, adc_data, adc_valid, frame_out, locked, align_fail},
        64'd0);
    chk("rst_counters", {slip_count, frame_err_cnt, relock_cnt}, 64'd0);
    $display("reset checked");

    // 1: aligned frame, lock 17 cycles after serdes_rdy
    rst_in = 1'b0;
    tick();
    serdes_rdy = 1'b1;
    clear_pulses();
    for (int n = 1; n <= 17; n++) begin
      tick();
      if (n == 16) chk("lock_not_early", locked, 1'b0);
    end
    chk("lock_at_17", locked, 1'b1);
    chk("no_slip_aligned", pulse_cnt, 0);
    chk("slip_count_0", slip_count, 0);
    tick();
    chk("valid_after_lock", adc_valid, 1'b1);
    $display("aligned lock: locked=%0d slips=%0d", locked, pulse_cnt);

    // Randomized data against the mapping model
    for (int t = 0; t < 12; t++) begin
      data_raw = $urandom();
      drive_raw();
      tick();
      chk("rand_adc", adc_data, exp_adc(raw_prev));
      chk("rand_frame", frame_out, exp_frame(raw_prev));
      $display("rand txn %0d raw=%09h adc=%08h", t, raw_prev, adc_data);
    end

    // 4: walking one with polarity pre-compensated, then all-zero raw
    set_data_mod(32'h0000_0010); tick();
    chk("walk_lane1_s0", adc_data[15:0], 16'h4000);
    set_data_mod(32'h0000_0002); tick();
    chk("walk_lane0_s1", adc_data[15:0], 16'h2000);
    set_data_mod(32'h0000_0100); tick();
    chk("walk_lane2_s0", adc_data[15:0], 16'h0080);
    data_raw = '0; drive_raw(); tick();
    e = exp_adc(raw_prev);
    chk("zero_raw_ch1", adc_data[31:16], e[31:16]);
    $display("walking one ch1=%04h", adc_data[31:16]);

    // 5: isolated mismatches, then a lock loss
    frame_bad = 1'b1; drive_raw();
    repeat (3) tick();
    frame_bad = 1'b0; drive_raw(); tick();
    chk("err3_locked", locked, 1'b1);
    chk("err3_cnt", frame_err_cnt, 16'd3);
    frame_bad = 1'b1; drive_raw();
    repeat (3) tick();
    chk("loss3_still_locked", locked, 1'b1);
    tick();
    frame_bad = 1'b0; drive_raw();
    chk("loss_unlocked", locked, 1'b0);
    chk("loss_valid_low", adc_valid, 1'b0);
    chk("loss_relock_cnt", relock_cnt, 8'd1);
    chk("loss_err_cnt", frame_err_cnt, 16'd7);
    repeat (15) tick();
    chk("relock_not_early", locked, 1'b0);
    tick();
    chk("relocked", locked, 1'b1);
    $display("lock loss: relock_cnt=%0d err=%0d", relock_cnt, frame_err_cnt);

    // 6b: train_start coincident with the 4th mismatch
    frame_bad = 1'b1; drive_raw();
    repeat (3) tick();
    train_start = 1'b1;
    tick();
    train_start = 1'b0; frame_bad = 1'b0; drive_raw();
    chk("train_err_clr", frame_err_cnt, 16'd0);
    chk("train_relock_0", relock_cnt, 8'd0);
    chk("train_unlocked", locked, 1'b0);
    repeat (16) tick();
    chk("train_relocked", locked, 1'b1);

    // serdes_rdy drop keeps statistics
    frame_bad = 1'b1; drive_raw(); tick();
    frame_bad = 1'b0; serdes_rdy = 1'b0; drive_raw(); tick();
    chk("rdy_drop_unlock", locked, 1'b0);
    chk("rdy_drop_err_kept", frame_err_cnt, 16'd1);
    serdes_rdy = 1'b1;
    $display("serdes_rdy drop: err=%0d", frame_err_cnt);

    // 2: frame rotated by two positions
    rst_in = 1'b1; tick(); tick();
    rst_in = 1'b0; rot = 2; drive_raw();
    clear_pulses();
    for (int n = 0; n < 100 && !locked; n++) tick();
    chk("rot_locked", locked, 1'b1);
    chk("rot_pulses", pulse_cnt, 2);
    chk("rot_gap_ok", (min_gap >= 6), 1'b1);
    chk("rot_slip_count", slip_count, 4'd2);
    $display("rotated frame: pulses=%0d gap=%0d", pulse_cnt, min_gap);

    // 6a: reset while in WAIT
    rst_in = 1'b1; tick();
    rst_in = 1'b0; rot = 2; drive_raw();
    clear_pulses();
    for (int n = 0; n < 40 && pulse_cnt == 0; n++) tick();
    chk("wait_reached", pulse_cnt, 1);
    rst_in = 1'b1;
    tick();
    chk("rstwait_outputs", {bitslip, adc_data, adc_valid, frame_out, locked, align_fail},
        64'd0);
    chk("rstwait_counters", {slip_count, frame_err_cnt, relock_cnt}, 64'd0);
    pc = pulse_cnt;
    tick();
    chk("rstwait_no_slip", pulse_cnt, pc);
    chk("rstwait_bitslip", bitslip, 1'b0);
    rst_in = 1'b0;

    // 3: dead frame lane -> FAIL, then retrain
    frame_zero = 1'b1; drive_raw();
    clear_pulses();
    for (int n = 0; n < 200 && !align_fail; n++) tick();
    chk("fail_flag", align_fail, 1'b1);
    chk("fail_pulses", pulse_cnt, 8);
    chk("fail_unlocked", {locked, adc_valid}, 2'b00);
    chk("fail_slip_count", slip_count, 4'd8);
    $display("dead frame: pulses=%0d align_fail=%0d", pulse_cnt, align_fail);
    train_start = 1'b1; frame_zero = 1'b0; rot = 0; drive_raw();
    tick();
    train_start = 1'b0;
    chk("retrain_fail_clr", align_fail, 1'b0);
    chk("retrain_slip_clr", slip_count, 4'd0);
    repeat (16) tick();
    chk("retrain_locked", locked, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
